lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
// - Load/store initiator between the CPU datapath and the word-wide data RAM.
// - The RAM only accepts aligned 32-bit words: combinational read with ena, write on posedge clk with wena.
// - This block turns lb/lbu/lh/lhu/lw/sb/sh/sw requests into RAM word accesses.
// - Sub-word stores are done as read-modify-write; loads are lane-extracted and sign/zero-extended.
// PARAMETERS
// - ADDR_W      32  byte-address width of CPU and RAM sides.
// - BIG_ENDIAN  0   0: byte offset 0 = bits[7:0]; 1: byte offset 0 = bits[31:24].
// PORTS
// - clk        in   1       system clock; single clock domain.
// - rst        in   1       synchronous, active-high reset.
// - cpu_req    in   1       request strobe; sampled only in IDLE.
// - cpu_we     in   1       1 = store, 0 = load.
// - cpu_size   in   2       00 byte, 01 half, 10 word, 11 illegal.
// - cpu_signed in   1       loads only: 1 = sign-extend, 0 = zero-extend.
// - cpu_addr   in   ADDR_W  byte address.
// - cpu_wdata  in   32      store data, right-justified.
// - cpu_rdata  out  32      extended load data; valid while cpu_done=1.
// - cpu_done   out  1       one-cycle completion pulse.
// - cpu_err    out  1       one-cycle pulse with cpu_done when the access was rejected.
// - cpu_busy   out  1       1 while state != IDLE.
// - mem_ena    out  1       RAM read enable.
// - mem_wena   out  1       RAM write enable.
// - mem_addr   out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
// - mem_wdata  out  32      full word to write.
// - mem_rdata  in   32      RAM read data, combinational from mem_addr.
// BEHAVIOUR
// - Reset: state=IDLE. cpu_rdata=0, cpu_done=0, cpu_err=0, cpu_busy=0.
//   mem_ena, mem_wena, mem_addr and mem_wdata are all 0.
// - Memory strobes are gated by !rst, so a reset cycle never writes RAM.
// - FSM: IDLE -> {RD, WR, RESP}; RD -> {WR, RESP}; WR -> RESP; RESP -> IDLE.
// - IDLE: on cpu_req, register we/size/signed/addr/wdata. Next state:
//   - word store -> WR
//   - load or sub-word store -> RD
//   - rejected access -> RESP with err flag set.
// - RD: mem_ena=1 and mem_rdata is captured into rbuf.
//   - load -> RESP with rdata = ext(lane(rbuf)).
//   - sub-word store -> WR.
// - WR: mem_wena=1. mem_wdata = cpu_wdata (word) or rbuf with the target lane(s) replaced.
// - RESP: cpu_done=1 (and cpu_err if flagged), then IDLE.
// - Latency from req cycle T: load/word-store done at T+2; sub-word store done at T+3; rejected done at T+1.
// - cpu_req outside IDLE is ignored; no queueing. The CPU must hold the request until done.
// - Lane select: byte uses addr[1:0]; half uses addr[1] (BIG_ENDIAN mirrors lane order).
// - Extension: byte/half sign-extend from bit 7/15 when cpu_signed=1, otherwise zero-extend.
// - Word loads ignore cpu_signed. Stores ignore cpu_signed and cpu_wdata bits above the access size.
// - Reset mid-operation (any state): back to IDLE next edge; no done pulse, no RAM write.
// - Outside RESP, cpu_rdata holds its last value.
// CONFIGURATION
// - Macro LSU_MISALIGN_TRAP_EN selects how misaligned and illegal accesses are handled.
// - Defined:
//   - half with addr[0]=1, word with addr[1:0]!=0, or size=11 is rejected.
//   - No RAM access; cpu_done and cpu_err pulse at T+1.
// - Undefined:
//   - low address bits are forced to alignment (half clears bit0, word clears bits1:0) and the access proceeds.
//   - size=11 is treated as word.
//   - cpu_err is tied to 0.
// STRUCTURE
// - Shared package lsu_pkg:
//   - SZ_BYTE/SZ_HALF/SZ_WORD encodings.
//   - FSM state encodings (IDLE, RD, WR, RESP).
//   - function is_misaligned(size, addr[1:0]).
// - One sub-module lsu_lane_align: combinational lane extract+extend (load) and lane merge (store), parameterised by BIG_ENDIAN.
// - FSM and registers stay in lsu_mem_master.
// TESTING
// - Preload word 0x10010000 = 0x8899AABB. lb addr 0x10010001 signed -> rdata 0xFFFFFFAA at T+2, one mem_ena cycle.
// - lhu addr 0x10010002 on the same word -> rdata 0x00008899; lh -> 0xFFFF8899.
// - sb 0x10010003, wdata 0x12345677 -> RD at T+1, WR at T+2 with mem_wdata 0x7799AABB, done at T+3.
// - sw 0x10010004, wdata 0xDEADBEEF -> mem_wena at T+1 only, no mem_ena, done at T+2; readback lw -> 0xDEADBEEF.
// - With LSU_MISALIGN_TRAP_EN, lw 0x10010002 -> done+err at T+1, mem_ena/mem_wena never high.
//   Without the macro -> reads word 0x10010000.
// - Assert rst during WR of an sh -> mem_wena stays 0, no done; next request after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: access size codes,
// FSM state encoding and the alignment check used when trapping is enabled.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // True when the access cannot be issued as-is: a half on an odd byte,
  // a word off a word boundary, or the reserved size code.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for the load/store master.
// Load side: picks the addressed byte/half out of a RAM word and extends it.
// Store side: replaces the addressed lane(s) of a previously read word.
// BIG_ENDIAN mirrors the lane order (offset 0 = bits[31:24]).
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] rword,
  input  logic [31:0] base,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [1:0]  blane;
  logic        hlane;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // Map the byte offset to a physical lane and extend the selected load lane
  always_comb begin
    blane = (BIG_ENDIAN != 0) ? ~off : off;
    hlane = (BIG_ENDIAN != 0) ? ~off[1] : off[1];
    bsel  = rword[{blane, 3'b000} +: 8];
    hsel  = rword[{hlane, 4'b0000} +: 16];
    case (size)
      SZ_BYTE: ld_data = {{24{sgn & bsel[7]}}, bsel};
      SZ_HALF: ld_data = {{16{sgn & hsel[15]}}, hsel};
      default: ld_data = rword;
    endcase
  end

  // Merge the right-justified store data into the addressed lane(s)
  always_comb begin
    st_word = base;
    case (size)
      SZ_BYTE: st_word[{blane, 3'b000} +: 8]  = wdata[7:0];
      SZ_HALF: st_word[{hlane, 4'b0000} +: 16] = wdata[15:0];
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the CPU datapath and a word-wide data RAM.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned/illegal accesses with
// cpu_err instead of forcing the address to alignment.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic              mem_ena,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state, state_nx;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf;
  logic [31:0]       rdata_q;

  logic [1:0]        size_n;
  logic [ADDR_W-1:0] addr_n;
  logic              rej_n;
  logic              accept;

  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  assign accept = (state == IDLE) && cpu_req;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  // Trapping build: keep the request as issued and flag anything not aligned
  always_comb begin
    size_n = cpu_size;
    addr_n = cpu_addr;
    rej_n  = is_misaligned(cpu_size, cpu_addr[1:0]);
  end

  // Error flag travels with the request until its completion pulse
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept)
      err_q <= rej_n;
  end

  assign cpu_err = !rst && (state == RESP) && err_q;
`else
  // Forgiving build: reserved size acts as word, low address bits are forced aligned
  always_comb begin
    rej_n  = 1'b0;
    size_n = (cpu_size == SZ_ILL) ? SZ_WORD : cpu_size;
    addr_n = cpu_addr;
    case (size_n)
      SZ_HALF: addr_n[0]   = 1'b0;
      SZ_WORD: addr_n[1:0] = 2'b00;
      default: addr_n      = cpu_addr;
    endcase
  end

  assign cpu_err = 1'b0;
`endif

  lsu_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .size    (size_q),
    .sgn     (sgn_q),
    .off     (addr_q[1:0]),
    .rword   (mem_rdata),
    .base    (rbuf),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state: word stores skip the read, sub-word stores read then write
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (rej_n)
            state_nx = RESP;
          else if (cpu_we && (size_n == SZ_WORD))
            state_nx = WR;
          else
            state_nx = RD;
        end
      end
      RD:      state_nx = we_q ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture and read buffer (pure data, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= cpu_we;
      size_q  <= size_n;
      sgn_q   <= cpu_signed;
      addr_q  <= addr_n;
      wdata_q <= cpu_wdata;
    end
    if (state == RD)
      rbuf <= mem_rdata;
  end

  // Load result register; holds its value between completions
  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= 32'h0;
    else if ((state == RD) && !we_q)
      rdata_q <= ld_data;
  end

  // Outputs decoded from state; every strobe is suppressed during reset
  always_comb begin
    mem_ena   = !rst && (state == RD);
    mem_wena  = !rst && (state == WR);
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (mem_ena || mem_wena)
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (mem_wena)
      mem_wdata = st_word;
    cpu_done  = !rst && (state == RESP);
    cpu_busy  = !rst && (state != IDLE);
    cpu_rdata = rdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small word RAM model.
module tb_lsu_mem_master;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_signed = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_busy;
  logic        mem_ena;
  logic        mem_wena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:15];
  logic        ram_init = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_ena;
    int          exp_wena;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [0:15];

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_size   (cpu_size),
    .cpu_signed (cpu_signed),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .cpu_busy   (cpu_busy),
    .mem_ena    (mem_ena),
    .mem_wena   (mem_wena),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[5:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++)
        ram[i] <= (i == 0) ? 32'h8899AABB : 32'h0;
    end else if (mem_wena) begin
      ram[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int          lat = 0;
    int          n_ena = 0;
    int          n_wena = 0;
    logic [31:0] wd = 32'h0;
    logic [31:0] ma = 32'h0;
    logic [31:0] rd = 32'h0;
    logic        er = 1'b0;
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = v.we;
    cpu_size   = v.size;
    cpu_signed = v.sgn;
    cpu_addr   = v.addr;
    cpu_wdata  = v.wdata;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk({tag, " busy"}, 32'(cpu_busy), 32'd1);
      if (mem_ena) begin n_ena++; ma = mem_addr; end
      if (mem_wena) begin n_wena++; wd = mem_wdata; ma = mem_addr; end
      if (cpu_done) begin
        lat = k;
        rd  = cpu_rdata;
        er  = cpu_err;
        break;
      end
    end
    cpu_req = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, " mem_ena cycles"}, 32'(n_ena), 32'(v.exp_ena));
    chk({tag, " mem_wena cycles"}, 32'(n_wena), 32'(v.exp_wena));
    chk({tag, " err"}, 32'(er), 32'(v.exp_err));
    if (v.exp_ena + v.exp_wena > 0)
      chk({tag, " mem_addr"}, ma, {v.addr[31:2], 2'b00});
    if (v.exp_wena > 0)
      chk({tag, " mem_wdata"}, wd, v.exp_wdata);
    if (!v.we && !v.exp_err)
      chk({tag, " rdata"}, rd, v.exp_rdata);
    @(posedge clk);
    #1;
    chk({tag, " done single pulse"}, 32'(cpu_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //           we sz  s  addr          wdata         rdata         lat ena wena wdata        err
    tbl[0]  = '{0, B, 1, 32'h10010001, 32'h0,        32'hFFFFFFAA, 2, 1, 0, 32'h0,        0};
    tbl[1]  = '{0, B, 0, 32'h10010001, 32'h0,        32'h000000AA, 2, 1, 0, 32'h0,        0};
    tbl[2]  = '{0, H, 0, 32'h10010002, 32'h0,        32'h00008899, 2, 1, 0, 32'h0,        0};
    tbl[3]  = '{0, H, 1, 32'h10010002, 32'h0,        32'hFFFF8899, 2, 1, 0, 32'h0,        0};
    tbl[4]  = '{0, B, 1, 32'h10010000, 32'h0,        32'hFFFFFFBB, 2, 1, 0, 32'h0,        0};
    tbl[5]  = '{0, B, 1, 32'h10010003, 32'h0,        32'hFFFFFF88, 2, 1, 0, 32'h0,        0};
    tbl[6]  = '{0, H, 1, 32'h10010000, 32'h0,        32'hFFFFAABB, 2, 1, 0, 32'h0,        0};
    tbl[7]  = '{0, W, 1, 32'h10010000, 32'h0,        32'h8899AABB, 2, 1, 0, 32'h0,        0};
    tbl[8]  = '{1, B, 0, 32'h10010003, 32'h12345677, 32'h0,        3, 1, 1, 32'h7799AABB, 0};
    tbl[9]  = '{0, W, 0, 32'h10010000, 32'h0,        32'h7799AABB, 2, 1, 0, 32'h0,        0};
    tbl[10] = '{1, W, 0, 32'h10010004, 32'hDEADBEEF, 32'h0,        2, 0, 1, 32'hDEADBEEF, 0};
    tbl[11] = '{0, W, 0, 32'h10010004, 32'h0,        32'hDEADBEEF, 2, 1, 0, 32'h0,        0};
    tbl[12] = '{1, H, 1, 32'h10010006, 32'hFFFF1234, 32'h0,        3, 1, 1, 32'h1234BEEF, 0};
    tbl[13] = '{0, B, 0, 32'h10010007, 32'h0,        32'h00000012, 2, 1, 0, 32'h0,        0};
    tbl[14] = '{1, B, 0, 32'h10010004, 32'h000000C5, 32'h0,        3, 1, 1, 32'h1234BEC5, 0};
    tbl[15] = '{0, H, 1, 32'h10010004, 32'h0,        32'hFFFFBEC5, 2, 1, 0, 32'h0,        0};

    // Reset: strobes stay low while rst is held
    repeat (3) @(posedge clk);
    #1;
    chk("in-reset mem_ena", 32'(mem_ena), 32'd0);
    chk("in-reset mem_wena", 32'(mem_wena), 32'd0);
    chk("in-reset done", 32'(cpu_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ram_init = 1'b0;
    @(posedge clk);
    #1;
    chk("reset cpu_rdata", cpu_rdata, 32'h0);
    chk("reset cpu_busy", 32'(cpu_busy), 32'd0);
    chk("reset cpu_err", 32'(cpu_err), 32'd0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset mem_ena", 32'(mem_ena), 32'd0);

    for (int i = 0; i < 16; i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Misaligned and illegal accesses
`ifdef LSU_MISALIGN_TRAP_EN
    v = '{0, W, 0, 32'h10010002, 32'h0, 32'h0, 1, 0, 0, 32'h0, 1};
    run_vec("lw misaligned", v);
    v = '{0, H, 1, 32'h10010005, 32'h0, 32'h0, 1, 0, 0, 32'h0, 1};
    run_vec("lh misaligned", v);
    v = '{1, H, 0, 32'h10010001, 32'h5555, 32'h0, 1, 0, 0, 32'h0, 1};
    run_vec("sh misaligned", v);
    v = '{0, X, 0, 32'h10010004, 32'h0, 32'h0, 1, 0, 0, 32'h0, 1};
    run_vec("size11", v);
`else
    v = '{0, W, 0, 32'h10010002, 32'h0, 32'h7799AABB, 2, 1, 0, 32'h0, 0};
    run_vec("lw misaligned", v);
    v = '{0, H, 1, 32'h10010005, 32'h0, 32'hFFFFBEC5, 2, 1, 0, 32'h0, 0};
    run_vec("lh misaligned", v);
    v = '{0, X, 0, 32'h10010004, 32'h0, 32'h1234BEC5, 2, 1, 0, 32'h0, 0};
    run_vec("size11 load", v);
`endif

    // Reset during the write phase of a half store
    @(negedge clk);
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_size   = H;
    cpu_signed = 1'b0;
    cpu_addr   = 32'h10010000;
    cpu_wdata  = 32'hAAAA5555;
    @(posedge clk);
    #1;
    chk("rmw abort RD phase", 32'(mem_ena), 32'd1);
    @(posedge clk);
    #1;
    chk("rmw abort WR phase", 32'(mem_wena), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmw abort wena gated", 32'(mem_wena), 32'd0);
    chk("rmw abort done gated", 32'(cpu_done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    chk("rmw abort idle", 32'(cpu_busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rmw abort no done %0d", k), 32'(cpu_done), 32'd0);
    end
    chk("rmw abort ram untouched", ram[0], 32'h7799AABB);
    v = '{0, W, 0, 32'h10010000, 32'h0, 32'h7799AABB, 2, 1, 0, 32'h0, 0};
    run_vec("post-reset lw", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
